// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: request/result bundle shared by N requesters and one
// downstream consumer around the adder_arbiter. The slave modport is the
// arbiter side; the master modport is the requester/consumer side.
interface adder_arbiter_if #(
    parameter int WIDTH      = 4,
    parameter int REQUESTERS = 4
);
    localparam int ID_W = $clog2(REQUESTERS);

    logic [REQUESTERS-1:0]       requestValid;
    logic [REQUESTERS-1:0]       requestReady;
    logic [REQUESTERS*WIDTH-1:0] requestOperand0;
    logic [REQUESTERS*WIDTH-1:0] requestOperand1;
    logic                        resultValid;
    logic                        resultReady;
    logic [WIDTH-1:0]            result;
    logic                        overflow;
    logic [ID_W-1:0]             resultId;

    modport slave (
        input  requestValid,
        input  requestOperand0,
        input  requestOperand1,
        input  resultReady,
        output requestReady,
        output resultValid,
        output result,
        output overflow,
        output resultId
    );

    modport master (
        output requestValid,
        output requestOperand0,
        output requestOperand1,
        output resultReady,
        input  requestReady,
        input  resultValid,
        input  result,
        input  overflow,
        input  resultId
    );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: a single signed adder shared round-robin between
// REQUESTERS requesters. One result register with a valid/ready output
// handshake; a drain and a new transfer in the same cycle replace the
// result without a bubble, so one result per cycle is sustained.
// Optional feature: define ADDER_ARBITER_SATURATE_EN to clamp overflowing
// sums to the signed extremes instead of wrapping (overflow still flagged).
module adder_arbiter #(
    parameter int WIDTH      = 4,
    parameter int REQUESTERS = 4
) (
    input  logic              clock,
    input  logic              resetN,
    adder_arbiter_if.slave    arb
);
    localparam int              ID_W    = $clog2(REQUESTERS);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(REQUESTERS - 1);
    localparam logic [ID_W:0]   N_EXT   = (ID_W+1)'(REQUESTERS);

    // Signed add returning {overflow, sum}; saturates when the feature is on.
    function automatic logic [WIDTH:0] add_checked(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] s;
        logic             o;
        s = a + b;
        o = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
`ifdef ADDER_ARBITER_SATURATE_EN
        if (o) begin
            // Equal operand signs on overflow: a's sign picks the rail.
            if (a[WIDTH-1]) begin
                s = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                s = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            s = s;
        end
`endif
        return {o, s};
    endfunction

    logic [ID_W-1:0]       pointer_r;
    logic [ID_W-1:0]       grant_id_s;
    logic [ID_W-1:0]       pointer_next_s;
    logic [ID_W:0]         cand_s;
    logic                  grant_found_s;
    logic                  can_accept_s;
    logic                  transfer_s;
    logic [REQUESTERS-1:0] ready_s;
    logic [WIDTH-1:0]      op0_a [REQUESTERS];
    logic [WIDTH-1:0]      op1_a [REQUESTERS];
    logic [WIDTH-1:0]      sum_s;
    logic                  ovf_s;
    logic [WIDTH-1:0]      result_r;
    logic                  overflow_r;
    logic [ID_W-1:0]       result_id_r;
    logic                  result_valid_r;

    genvar gi;
    generate
        for (gi = 0; gi < REQUESTERS; gi++) begin : g_unpack
            assign op0_a[gi] = arb.requestOperand0[gi*WIDTH +: WIDTH];
            assign op1_a[gi] = arb.requestOperand1[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = pointer_r;
        cand_s        = {(ID_W+1){1'b0}};
        for (int k = 0; k < REQUESTERS; k++) begin
            cand_s = {1'b0, pointer_r} + (ID_W+1)'(k);
            if (cand_s >= N_EXT) begin
                cand_s = cand_s - N_EXT;
            end else begin
                cand_s = cand_s;
            end
            if (!grant_found_s && arb.requestValid[cand_s[ID_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_id_s    = cand_s[ID_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Handshake, transfer decision, next pointer and the adder datapath.
    always_comb begin
        ready_s        = {REQUESTERS{1'b0}};
        can_accept_s   = !result_valid_r || arb.resultReady;
        transfer_s     = grant_found_s && can_accept_s && resetN;
        {ovf_s, sum_s} = add_checked(op0_a[grant_id_s], op1_a[grant_id_s]);
        if (transfer_s) begin
            ready_s[grant_id_s] = 1'b1;
        end else begin
            ready_s = {REQUESTERS{1'b0}};
        end
        if (grant_id_s == LAST_ID) begin
            pointer_next_s = {ID_W{1'b0}};
        end else begin
            pointer_next_s = grant_id_s + {{(ID_W-1){1'b0}}, 1'b1};
        end
    end

    // Result register, valid flag and round-robin pointer.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            result_valid_r <= 1'b0;
            result_r       <= {WIDTH{1'b0}};
            overflow_r     <= 1'b0;
            result_id_r    <= {ID_W{1'b0}};
            pointer_r      <= {ID_W{1'b0}};
        end else if (transfer_s) begin
            result_valid_r <= 1'b1;
            result_r       <= sum_s;
            overflow_r     <= ovf_s;
            result_id_r    <= grant_id_s;
            pointer_r      <= pointer_next_s;
        end else if (arb.resultReady) begin
            result_valid_r <= 1'b0;
        end else begin
            result_valid_r <= result_valid_r;
        end
    end

    assign arb.requestReady = ready_s;
    assign arb.resultValid  = result_valid_r;
    assign arb.result       = result_r;
    assign arb.overflow     = overflow_r;
    assign arb.resultId     = result_id_r;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed scenarios plus randomized traffic checked
// against an arithmetic reference model of the shared adder/arbiter.
module tb_adder_arbiter;
    localparam int W = 4;
    localparam int N = 4;

    logic clock = 1'b0;
    logic resetN;
    always #5 clock = ~clock;

    adder_arbiter_if #(.WIDTH(W), .REQUESTERS(N)) arb();
    adder_arbiter #(.WIDTH(W), .REQUESTERS(N)) dut (
        .clock (clock),
        .resetN(resetN),
        .arb   (arb)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_valid;
    int m_result;
    bit m_ovf;
    int m_id;
    int m_ptr;

    function automatic int sx(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    function automatic int op_of(input logic [15:0] bus, input int i);
        return sx(bus[i*4 +: 4]);
    endfunction

    function automatic void model_sum(input int a, input int b, output int r, output bit o);
        int s;
        s = a + b;
        o = (s > 7) || (s < -8);
`ifdef ADDER_ARBITER_SATURATE_EN
        r = o ? ((s > 0) ? 7 : -8) : s;
`else
        r = o ? ((s > 7) ? s - 16 : s + 16) : s;
`endif
    endfunction

    function automatic logic [3:0] model_ready();
        bit can;
        int idx;
        if (!resetN) return 4'b0000;
        can = !m_valid || arb.resultReady;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (arb.requestValid[idx]) return can ? 4'(1 << idx) : 4'b0000;
        end
        return 4'b0000;
    endfunction

    task automatic set_req(input int i, input int a, input int b);
        arb.requestOperand0[i*4 +: 4] = a[3:0];
        arb.requestOperand1[i*4 +: 4] = b[3:0];
    endtask

    // One clock edge; the model advances from the values seen just before it.
    task automatic tick(output logic [3:0] acc);
        int g;
        int a;
        int b;
        int r;
        bit o;
        bit rr;
        bit rn;
        acc = model_ready();
        g = -1;
        for (int k = 0; k < N; k++) if (acc[k]) g = k;
        a = 0;
        b = 0;
        if (g >= 0) begin
            a = op_of(arb.requestOperand0, g);
            b = op_of(arb.requestOperand1, g);
        end
        rr = arb.resultReady;
        rn = resetN;
        @(posedge clock);
        if (!rn) begin
            m_valid = 0; m_result = 0; m_ovf = 0; m_id = 0; m_ptr = 0;
        end else if (g >= 0) begin
            model_sum(a, b, r, o);
            m_valid = 1; m_result = r; m_ovf = o; m_id = g; m_ptr = (g + 1) % N;
        end else if (m_valid && rr) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] acc;
        resetN = 1'b0;
        arb.requestValid = 4'b1111;
        arb.resultReady = 1'b1;
        #1;
        checks++;
        if (arb.requestReady !== 4'b0000) begin
            errors++; $display("FAIL reset_ready: got %b expected 0000", arb.requestReady);
        end
        tick(acc);
        checks++;
        if (arb.resultValid !== 1'b0 || arb.result !== 4'h0 || arb.overflow !== 1'b0 || arb.resultId !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b r=%h o=%b id=%0d expected 0 0 0 0",
                     arb.resultValid, arb.result, arb.overflow, arb.resultId);
        end
        resetN = 1'b1;
        arb.requestValid = 4'b0000;
    endtask

    task automatic test_single();
        logic [3:0] acc;
        set_req(1, 3, 2);
        arb.requestValid = 4'b0010;
        arb.resultReady = 1'b1;
        #1;
        checks++;
        if (arb.requestReady !== 4'b0010) begin
            errors++; $display("FAIL single_ready: got %b expected 0010", arb.requestReady);
        end
        tick(acc);
        arb.requestValid = 4'b0000;
        checks++;
        if (arb.resultValid !== 1'b1 || arb.result !== 4'd5 || arb.overflow !== 1'b0 || arb.resultId !== 2'd1) begin
            errors++;
            $display("FAIL single_result: got v=%b r=%h o=%b id=%0d expected 1 5 0 1",
                     arb.resultValid, arb.result, arb.overflow, arb.resultId);
        end
        tick(acc);
        checks++;
        if (arb.resultValid !== 1'b0) begin
            errors++; $display("FAIL single_drain: got valid=%b expected 0", arb.resultValid);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] acc;
        logic [3:0] exp_r;
        int a;
        int b;
        for (int c = 0; c < 2; c++) begin
            a = (c == 0) ? 7 : -8;
            b = (c == 0) ? 1 : -1;
`ifdef ADDER_ARBITER_SATURATE_EN
            exp_r = (c == 0) ? 4'h7 : 4'h8;
`else
            exp_r = (c == 0) ? 4'h8 : 4'h7;
`endif
            set_req(3, a, b);
            arb.requestValid = 4'b1000;
            #1;
            tick(acc);
            arb.requestValid = 4'b0000;
            checks++;
            if (arb.result !== exp_r || arb.overflow !== 1'b1 || arb.resultId !== 2'd3) begin
                errors++;
                $display("FAIL overflow_%0d: got r=%h o=%b id=%0d expected r=%h o=1 id=3",
                         c, arb.result, arb.overflow, arb.resultId, exp_r);
            end
            tick(acc);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] acc;
        resetN = 1'b0;
        tick(acc);
        resetN = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 15), $urandom_range(0, 15));
        arb.requestValid = 4'b1111;
        arb.resultReady = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(acc);
            checks++;
            if (arb.resultValid !== 1'b1 || arb.resultId !== 2'(c % 4) || arb.result !== m_result[3:0]) begin
                errors++;
                $display("FAIL b2b_%0d: got v=%b id=%0d r=%h expected 1 %0d %h",
                         c, arb.resultValid, arb.resultId, arb.result, c % 4, m_result[3:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] acc;
        logic [3:0] held;
        held = m_result[3:0];
        arb.resultReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (arb.requestReady !== 4'b0000) begin
                errors++; $display("FAIL bp_ready_%0d: got %b expected 0000", c, arb.requestReady);
            end
            tick(acc);
            checks++;
            if (arb.resultValid !== 1'b1 || arb.result !== held || arb.resultId !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%b r=%h id=%0d expected 1 %h 0",
                         c, arb.resultValid, arb.result, arb.resultId, held);
            end
        end
        arb.resultReady = 1'b1;
        #1;
        checks++;
        if (arb.requestReady !== 4'b0010) begin
            errors++; $display("FAIL bp_release_ready: got %b expected 0010", arb.requestReady);
        end
        tick(acc);
        checks++;
        if (arb.resultValid !== 1'b1 || arb.resultId !== 2'd1 || arb.result !== m_result[3:0]) begin
            errors++;
            $display("FAIL bp_release_result: got v=%b id=%0d r=%h expected 1 1 %h",
                     arb.resultValid, arb.resultId, arb.result, m_result[3:0]);
        end
        arb.requestValid = 4'b0000;
        tick(acc);
    endtask

    task automatic test_reset_mid();
        logic [3:0] acc;
        resetN = 1'b0;
        tick(acc);
        resetN = 1'b1;
        arb.resultReady = 1'b0;
        set_req(1, 1, 1);
        arb.requestValid = 4'b0010;
        tick(acc);
        arb.requestValid = 4'b1001;
        resetN = 1'b0;
        #1;
        checks++;
        if (arb.requestReady !== 4'b0000) begin
            errors++; $display("FAIL midreset_ready: got %b expected 0000", arb.requestReady);
        end
        tick(acc);
        checks++;
        if (arb.resultValid !== 1'b0) begin
            errors++; $display("FAIL midreset_valid: got %b expected 0", arb.resultValid);
        end
        resetN = 1'b1;
        #1;
        checks++;
        if (arb.requestReady !== 4'b0001) begin
            errors++; $display("FAIL midreset_grant: got %b expected 0001", arb.requestReady);
        end
        tick(acc);
        checks++;
        if (arb.resultId !== 2'd0 || arb.resultValid !== 1'b1) begin
            errors++; $display("FAIL midreset_id: got id=%0d v=%b expected 0 1", arb.resultId, arb.resultValid);
        end
        arb.requestValid = 4'b0000;
        arb.resultReady = 1'b1;
        tick(acc);
    endtask

    task automatic test_random();
        logic [3:0] acc;
        logic [3:0] exp_rdy;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!arb.requestValid[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, $urandom_range(0, 15), $urandom_range(0, 15));
                    arb.requestValid[i] = 1'b1;
                end
            end
            arb.resultReady = ($urandom_range(0, 3) != 0);
            resetN = ($urandom_range(0, 60) != 0);
            #1;
            exp_rdy = model_ready();
            checks++;
            if (arb.requestReady !== exp_rdy) begin
                errors++; $display("FAIL rand_ready_%0d: got %b expected %b", c, arb.requestReady, exp_rdy);
            end
            tick(acc);
            arb.requestValid = arb.requestValid & ~acc;
            checks++;
            if (arb.resultValid !== m_valid || arb.result !== m_result[3:0] ||
                arb.overflow !== m_ovf || arb.resultId !== m_id[1:0]) begin
                errors++;
                $display("FAIL rand_out_%0d: got v=%b r=%h o=%b id=%0d expected %b %h %b %0d",
                         c, arb.resultValid, arb.result, arb.overflow, arb.resultId,
                         m_valid, m_result[3:0], m_ovf, m_id);
            end
        end
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b0;
        arb.requestValid = 4'b0000;
        arb.requestOperand0 = 16'h0000;
        arb.requestOperand1 = 16'h0000;
        arb.resultReady = 1'b1;
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the operand/result width in bits (signed two's complement).
REQ-002 The block SHALL have parameter REQUESTERS, default 4, the number of requesters sharing the adder (2..8).
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resetN, input, 1, synchronous, active-low reset.
REQ-005 The block SHALL have port requestValid, input, REQUESTERS, per-requester operation request.
REQ-006 The block SHALL have port requestReady, output, REQUESTERS, per-requester acceptance strobe; at most one bit set.
REQ-007 The block SHALL have port requestOperand0, input, REQUESTERS*WIDTH, flat bus; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port requestOperand1, input, REQUESTERS*WIDTH, same packing as requestOperand0.
REQ-009 The block SHALL have port resultValid, output, 1, result register holds an unconsumed result.
REQ-010 The block SHALL have port resultReady, input, 1, downstream accepts the result.
REQ-011 The block SHALL have port result, output, WIDTH, signed sum.
REQ-012 The block SHALL have port overflow, output, 1, signed overflow of that sum.
REQ-013 The block SHALL have port resultId, output, clog2(REQUESTERS), index of the requester that issued the result.

Function
REQ-014 The block SHALL be able to accept a request ("canAccept") when resultValid=0 or (resultValid=1 and resultReady=1).
REQ-015 The block SHALL select a grant round-robin: the lowest-index valid requester at or after pointer, wrapping from REQUESTERS-1 to 0.
REQ-016 The block SHALL assert requestReady[g] combinationally only when requester g is granted and canAccept=1; all other bits 0.
REQ-017 A transfer SHALL occur when requestValid[g] and requestReady[g] are both 1 on a rising edge.
REQ-018 On transfer, the block SHALL load result=operand0+operand1 (mod 2^WIDTH), overflow, and resultId=g, and set resultValid=1 the following cycle (latency 1).
REQ-019 overflow SHALL be 1 iff operand signs are equal and the result sign differs from them.
REQ-020 On transfer, pointer SHALL become (g+1) mod REQUESTERS; without a transfer, pointer SHALL hold.
REQ-021 If resultValid=1, resultReady=1 and no transfer occurs, resultValid SHALL clear to 0.
REQ-022 If resultValid=1 and resultReady=0, result, overflow and resultId SHALL hold stable, and requestReady SHALL be all 0.
REQ-023 Simultaneous drain and transfer SHALL replace the result with no bubble (one result per cycle sustained).
REQ-024 requestReady SHALL NOT depend on the requester's own operands; requesters hold requestValid and operands until accepted.

Reset
REQ-025 While resetN=0 at a rising edge, resultValid=0, result=0, overflow=0, resultId=0, and pointer=0.
REQ-026 requestReady SHALL be all 0 while resetN=0; a reset mid-operation discards any pending result with no transfer completed.

Configuration
REQ-027 With ADDER_ARBITER_SATURATE_EN defined, the block SHALL load result with the saturated value on overflow: 2^(WIDTH-1)-1 if both operands are non-negative, else -2^(WIDTH-1); overflow is still reported as 1.
REQ-028 Without ADDER_ARBITER_SATURATE_EN, result SHALL be the wrapped sum.

Verification (WIDTH=4, REQUESTERS=4)
REQ-029 Scenario: requester 1 only, 3+2, resultReady=1 -> next cycle resultValid=1, result=5, overflow=0, resultId=1.
REQ-030 Scenario: 7+1 -> result=-8, overflow=1; with ADDER_ARBITER_SATURATE_EN, result=7, overflow=1.
REQ-031 Scenario: -8+(-1) -> result=7, overflow=1; with ADDER_ARBITER_SATURATE_EN, result=-8, overflow=1.
REQ-032 Scenario: all four requestValid held at 1, resultReady=1 -> resultId sequence 0,1,2,3,0 on consecutive cycles, with no idle cycle.
REQ-033 Scenario: resultReady=0 with resultValid=1 for 3 cycles -> result stable and requestReady=0000; resultReady rises -> pending request accepted in that same cycle, and the new result appears next cycle.
REQ-034 Scenario: resetN=0 for one edge while resultValid=1 and pointer=2 -> resultValid=0, pointer=0; afterwards requesters 0 and 3 valid -> requester 0 granted first.
